// File: rtl/dsp_sensor_pkg.sv
// Shared types and helpers for the sensor-array tap calibrator.
// Latency: n/a (package only).
// Backpressure: n/a.
package dsp_sensor_pkg;

  // Width of every tap-delay control word.
  localparam int TAP_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACC    = 3'd2,
    ST_EVAL   = 3'd3,
    ST_LOCKED = 3'd4
  } cal_state_e;

  // Bits needed to hold the total popcount of nch words of pw bits.
  function automatic int sum_width(input int nch, input int pw);
    return $clog2(nch * pw + 1);
  endfunction

endpackage

// File: rtl/sensor_popcount.sv
// Registered popcount of one sensor channel's P word.
// Latency: 1 cycle from p_i to cnt_o.
// Backpressure: none, produces a result every cycle.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   p_i         - channel P word
//   cnt_o       - number of ones in p_i, registered
module sensor_popcount #(
  parameter int PW = 48,
  localparam int CW = $clog2(PW + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] p_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < PW; i++) begin
      cnt_d = cnt_d + CW'(p_i[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dsp_sensor_array_cal.sv
// Sweeps the data-path tap over all 32 values, picks the tap whose averaged
// sensor popcount is closest to half-scale, then streams popcount sums.
// Latency: sensor_p -> sum 2 cycles; sum -> out_data 1 cycle; full sweep
// 32*(SETTLE+2^AVG_LOG2+1) cycles. Backpressure: valid/ready output; samples
// arriving while a sample is stalled are dropped and counted in drop_cnt.
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   sensor_p              - NCH concatenated P words, channel 0 in the LSBs
//   cfg_taps_clk/taps_clk - clock-path tap request and its registered copy
//   cal_start             - single-cycle calibration request
//   taps_A                - data-path tap driven to every channel
//   busy, locked          - sweep in progress / tap chosen and streaming
//   cal_done              - one-cycle pulse on lock
//   best_err              - |mean - NCH*PW/2| of the chosen tap
//   out_data/valid/ready  - popcount-sum sample stream
//   drop_cnt              - saturating count of dropped samples
module dsp_sensor_array_cal
  import dsp_sensor_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PW       = 48,
  parameter int SETTLE   = 8,
  parameter int AVG_LOG2 = 4,
  localparam int SW      = sum_width(NCH, PW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*PW-1:0]    sensor_p,
  input  logic [TAP_W-1:0]     cfg_taps_clk,
  input  logic                 cal_start,
  output logic [TAP_W-1:0]     taps_clk,
  output logic [TAP_W-1:0]     taps_A,
  output logic                 busy,
  output logic                 locked,
  output logic                 cal_done,
  output logic [SW-1:0]        best_err,
  output logic [SW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          drop_cnt
);

  localparam int CW = $clog2(PW + 1);
  localparam int AW = SW + AVG_LOG2;
  localparam logic [SW-1:0]    TARGET      = SW'(NCH * PW / 2);
  localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0]      ACC_LAST    = 16'((1 << AVG_LOG2) - 1);
  localparam logic [TAP_W-1:0] TAP_LAST    = '1;

  // Popcount pipeline: per-channel count, then channel sum.
  logic [CW-1:0] pc [NCH];
  logic [SW-1:0] sum_d, sum_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sensor_popcount #(.PW(PW)) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .p_i   (sensor_p[g*PW +: PW]),
      .cnt_o (pc[g])
    );
  end

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NCH; c++) begin
      sum_d = sum_d + SW'(pc[c]);
    end
  end

  // Calibration and stream state.
  cal_state_e       state_d, state_q;
  logic [15:0]      cnt_d, cnt_q;
  logic [AW-1:0]    acc_d, acc_q;
  logic [TAP_W-1:0] taps_a_d, taps_a_q;
  logic [TAP_W-1:0] best_tap_d, best_tap_q;
  logic [SW-1:0]    best_err_d, best_err_q;
  logic             cal_done_d, cal_done_q;
  logic             restart_d, restart_q;
  logic             out_vld_d, out_vld_q;
  logic [SW-1:0]    out_dat_d, out_dat_q;
  logic [15:0]      drop_d, drop_q;
  logic [TAP_W-1:0] taps_clk_q;

  logic [SW-1:0]    mean;
  logic [SW-1:0]    err;
  logic             better;
  logic [TAP_W-1:0] tap_pick;
  logic             slot_free;
  logic             start;

  // Averaging is a plain shift; strict compare keeps the lowest tap on ties.
  assign mean      = acc_q[AW-1:AVG_LOG2];
  assign err       = (mean >= TARGET) ? (mean - TARGET) : (TARGET - mean);
  assign better    = (err < best_err_q);
  assign tap_pick  = better ? taps_a_q : best_tap_q;
  assign slot_free = !out_vld_q || out_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    taps_a_d   = taps_a_q;
    best_tap_d = best_tap_q;
    best_err_d = best_err_q;
    cal_done_d = 1'b0;
    restart_d  = restart_q;
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    drop_d     = drop_q;
    start      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start = cal_start;
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_ACC;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_ACC: begin
        acc_d = acc_q + AW'(sum_q);
        if (cnt_q == ACC_LAST) begin
          state_d = ST_EVAL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_EVAL: begin
        best_tap_d = tap_pick;
        if (better) begin
          best_err_d = err;
        end
        if (taps_a_q == TAP_LAST) begin
          state_d    = ST_LOCKED;
          taps_a_d   = tap_pick;
          cal_done_d = 1'b1;
        end else begin
          state_d  = ST_SETTLE;
          taps_a_d = taps_a_q + TAP_W'(1);
          cnt_d    = '0;
        end
      end

      ST_LOCKED: begin
        if (restart_q || cal_start) begin
          // Recalibration requested: stop sampling and wait for any
          // stalled sample to be taken before restarting the sweep.
          restart_d = 1'b1;
          if (out_vld_q && out_ready) begin
            out_vld_d = 1'b0;
          end
          start = slot_free;
        end else if (slot_free) begin
          out_dat_d = sum_q;
          out_vld_d = 1'b1;
        end else if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start) begin
      state_d    = ST_SETTLE;
      cnt_d      = '0;
      taps_a_d   = '0;
      best_tap_d = '0;
      best_err_d = '1;
      drop_d     = '0;
      restart_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q      <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      taps_a_q   <= '0;
      best_tap_q <= '0;
      best_err_q <= '0;
      cal_done_q <= 1'b0;
      restart_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      drop_q     <= '0;
      taps_clk_q <= '0;
    end else begin
      sum_q      <= sum_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      taps_a_q   <= taps_a_d;
      best_tap_q <= best_tap_d;
      best_err_q <= best_err_d;
      cal_done_q <= cal_done_d;
      restart_q  <= restart_d;
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      drop_q     <= drop_d;
      taps_clk_q <= cfg_taps_clk;
    end
  end

  assign taps_clk  = taps_clk_q;
  assign taps_A    = taps_a_q;
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_ACC) ||
                     (state_q == ST_EVAL);
  assign locked    = (state_q == ST_LOCKED) && !restart_q;
  assign cal_done  = cal_done_q;
  assign best_err  = best_err_q;
  assign out_data  = out_dat_q;
  assign out_valid = out_vld_q;
  assign drop_cnt  = drop_q;

endmodule

// File: doc/dsp_sensor_array_cal.md
DSP_SENSOR_ARRAY_CAL -- requirements
Module: dsp_sensor_array_cal

Interface
REQ-001 SHALL have parameter NCH, default 4, number of DSP sensor channels (1..8).
REQ-002 SHALL have parameter PW, default 48, width of each channel's P word.
REQ-003 SHALL have parameter SETTLE, default 8, wait cycles after each taps_A change (>=3).
REQ-004 SHALL have parameter AVG_LOG2, default 4, log2 of samples averaged per tap.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port sensor_p, input, NCH*PW, concatenated channel P words already synchronous to clk; channel 0 in the LSBs.
REQ-008 SHALL have port cfg_taps_clk, input, 5, the requested clock-path tap value.
REQ-009 SHALL have port cal_start, input, 1, single-cycle calibration request.
REQ-010 SHALL have port taps_clk, output, 5, registered copy of cfg_taps_clk.
REQ-011 SHALL have port taps_A, output, 5, data-path tap value driven to every channel.
REQ-012 SHALL have port busy, locked, output, 1 each, status.
REQ-013 SHALL have port cal_done, output, 1, one-cycle pulse.
REQ-014 SHALL have port best_err, output, SW, absolute error of the chosen tap.
REQ-015 SHALL have port out_data, out_valid, out_ready, SW/1/1, sample stream (out_ready is an input).
REQ-016 SHALL have port drop_cnt, output, 16, count of dropped samples.

Function
REQ-017 SHALL compute the popcount of each channel, registered, then the sum over channels, registered; sensor_p at cycle t appears in sum at cycle t+2. Sum width SW = clog2(NCH*PW+1).
REQ-018 SHALL implement the FSM states IDLE, SETTLE, ACC, EVAL and LOCKED.
REQ-019 SHALL move IDLE->SETTLE on cal_start, with taps_A=0, best_err=all-ones and best_tap=0.
REQ-020 SHALL move SETTLE->ACC after exactly SETTLE cycles, with the accumulator cleared.
REQ-021 SHALL add sum into a (SW+AVG_LOG2)-bit accumulator on each ACC cycle, and move to EVAL after 2^AVG_LOG2 cycles.
REQ-022 SHALL in EVAL (one cycle) compute mean = acc>>AVG_LOG2 and err = |mean - NCH*PW/2|, and update best_err/best_tap when err < best_err strictly, so the lowest tap wins ties.
REQ-023 SHALL from EVAL go to SETTLE with taps_A+1 if taps_A<31, else to LOCKED.
REQ-024 SHALL on entering LOCKED set taps_A=best_tap, pulse cal_done for one cycle, and set locked=1.
REQ-025 SHALL take exactly 32*(SETTLE+2^AVG_LOG2+1) cycles from the cal_start cycle to the cal_done cycle; the default is 800.
REQ-026 SHALL hold busy=1 in SETTLE, ACC and EVAL, and ignore cal_start while busy.
REQ-027 SHALL in LOCKED offer each cycle's sum as a stream sample: if out_valid=0 or out_ready=1, load out_data and set out_valid=1; otherwise drop the sample and increment drop_cnt, saturating at 65535.
REQ-028 SHALL hold out_valid and out_data stable until out_ready; an accepted sample with no new sample clears out_valid.
REQ-029 SHALL on cal_start in LOCKED clear locked, but defer entry to SETTLE until no sample is pending (out_valid=0, or out_ready=1 that cycle); no sample is generated after cal_start, and drop_cnt clears on entry to SETTLE.
REQ-030 SHALL register taps_clk from cfg_taps_clk every cycle.

Reset
REQ-031 SHALL on rst_n=0 at a clk edge, from any state including mid-calibration, set state=IDLE, taps_A=0, taps_clk=0, busy=0, locked=0, cal_done=0, best_err=0, out_valid=0, out_data=0, drop_cnt=0, and clear the pipeline registers.

Structure
REQ-032 SHALL place the FSM state enum, the tap width (5) and the SW function in shared package dsp_sensor_pkg.
REQ-033 SHALL instantiate a per-channel registered popcount sub-module sensor_popcount (PW in, clog2(PW+1) out), NCH times.

Verification
REQ-034 SHALL cover: NCH=4, all sensor_p=0 constant -> every err=96, best_tap=0, best_err=96, cal_done 800 cycles after cal_start.
REQ-035 SHALL cover: sensor_p popcount total = 96 only while taps_A=13 (0 otherwise) -> taps_A=13, best_err=0, locked=1.
REQ-036 SHALL cover: error equal at taps 5 and 20 (minimum) -> taps_A=5.
REQ-037 SHALL cover: LOCKED, out_ready=0 for 10 cycles -> out_data frozen at first sample, drop_cnt=9 (drops in the last 9 stalled cycles); then out_ready=1 -> a new sample every cycle.
REQ-038 SHALL cover: rst_n=0 during ACC at tap 7 -> next cycle IDLE with all outputs 0; a new cal_start restarts at taps_A=0.
REQ-039 SHALL cover: cal_start while busy -> ignored, cal_done still at cycle 800; cal_start in LOCKED with out_valid=1, out_ready=0 -> SETTLE only after the handshake completes.
